// File: rtl/raster_pkg.sv
// Shared raster-pipe types for the sample iterator: walk states, subsample codes
// and the subsample-to-grid-step mapping.
package raster_pkg;

    typedef enum logic {
        WAIT = 1'b0,
        TEST = 1'b1
    } iter_state_t;

    localparam logic [3:0] SS_1X  = 4'b1000;
    localparam logic [3:0] SS_4X  = 4'b0100;
    localparam logic [3:0] SS_16X = 4'b0010;
    localparam logic [3:0] SS_64X = 4'b0001;

    // Grid pitch in fixed point; an unrecognised code falls back to 1x.
    function automatic int unsigned ss_step(input logic [3:0] sub_sample, input int radix);
        case (sub_sample)
            SS_4X:   return 32'd1 << (radix - 1);
            SS_16X:  return 32'd1 << (radix - 2);
            SS_64X:  return 32'd1 << (radix - 3);
            default: return 32'd1 << radix;
        endcase
    endfunction

endpackage

// File: rtl/sample_iterator_if.sv
// Bus between bbox (R13 side), the sample iterator and sampletest (R14 side).
// Handshake: a triangle moves when validTri_R13H=1 at a clk edge while halt_RnnnnH=1; validSamp_R14H qualifies each sample.
interface sample_iterator_if #(
    parameter int SIGFIG = 24,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
);
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R13U;
    logic [1:0][1:0][SIGFIG-1:0]            box_R13S;
    logic                                   validTri_R13H;
    logic [3:0]                             subSample_RnnnnU;
    logic                                   halt_RnnnnH;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R14U;
    logic [1:0][SIGFIG-1:0]                 sample_R14S;
    logic                                   validSamp_R14H;

    modport master (
        output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
        input  halt_RnnnnH, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );

    modport slave (
        input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
        output halt_RnnnnH, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );
endinterface

// File: rtl/sample_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,15,13,4, seed 1) supplying sub-step sample jitter.
module sample_lfsr (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    output logic [15:0] value
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= 16'h0001;
        end else if (advance) begin
            value <= {value[14:0], value[15] ^ value[14] ^ value[12] ^ value[3]};
        end
    end

endmodule

// File: rtl/sample_iterator.sv
// Walks the sample grid of a triangle's bounding box, one sample per cycle, in raster order.
// Optional SAMPLE_JITTER_EN adds LFSR jitter (< step) to the emitted sample positions.
module sample_iterator
    import raster_pkg::*;
#(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic               clk,
    input  logic               rst,
    sample_iterator_if.slave   bus,
    output iter_state_t        state_dbg
);

    typedef logic signed [SIGFIG-1:0] coord_t;

    iter_state_t state_q, state_d;
    coord_t      x_q, x_d, y_q, y_d;
    coord_t      ll_x_q, ur_x_q, ur_y_q, step_q;
    logic        halt_q, halt_d, valid_q, valid_d, accept;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q;
    logic [COLORS-1:0][SIGFIG-1:0]          color_q;

    coord_t in_ll_x, in_ll_y, in_ur_x, in_ur_y, in_step, dx, dy;
    logic   box_aligned;

    assign in_ll_x = bus.box_R13S[0][0];
    assign in_ll_y = bus.box_R13S[0][1];
    assign in_ur_x = bus.box_R13S[1][0];
    assign in_ur_y = bus.box_R13S[1][1];
    assign in_step = coord_t'(ss_step(bus.subSample_RnnnnU, RADIX));
    assign dx      = in_ur_x - in_ll_x;
    assign dy      = in_ur_y - in_ll_y;
    assign box_aligned = ((dx & (in_step - coord_t'(1))) == '0) && !dx[SIGFIG-1]
                      && ((dy & (in_step - coord_t'(1))) == '0) && !dy[SIGFIG-1];

    // The walk ends on exact equality with UR, so an unaligned box would never terminate.
    assert property (@(posedge clk) disable iff (!rst)
        (state_q == WAIT && bus.validTri_R13H) |-> box_aligned);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        halt_d  = halt_q;
        valid_d = valid_q;
        accept  = 1'b0;
        case (state_q)
            WAIT: begin
                halt_d  = 1'b1;
                valid_d = 1'b0;
                if (bus.validTri_R13H) begin
                    accept  = 1'b1;
                    x_d     = in_ll_x;
                    y_d     = in_ll_y;
                    valid_d = 1'b1;
                    halt_d  = 1'b0;
                    state_d = TEST;
                end
            end
            TEST: begin
                if (x_q != ur_x_q) begin
                    x_d = x_q + step_q;
                end else if (y_q != ur_y_q) begin
                    x_d = ll_x_q;
                    y_d = y_q + step_q;
                end else begin
                    valid_d = 1'b0;
                    halt_d  = 1'b1;
                    state_d = WAIT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q     <= '0;
            y_q     <= '0;
            ll_x_q  <= '0;
            ur_x_q  <= '0;
            ur_y_q  <= '0;
            step_q  <= '0;
            halt_q  <= 1'b1;
            valid_q <= 1'b0;
            tri_q   <= '0;
            color_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            halt_q  <= halt_d;
            valid_q <= valid_d;
            if (accept) begin
                ll_x_q  <= in_ll_x;
                ur_x_q  <= in_ur_x;
                ur_y_q  <= in_ur_y;
                step_q  <= in_step;
                tri_q   <= bus.tri_R13S;
                color_q <= bus.color_R13U;
            end
        end
    end

`ifdef SAMPLE_JITTER_EN
    logic [15:0] lfsr_val;
    coord_t      mask_d, jit_x, jit_y, sx_q, sy_q;

    // One LFSR value per issued sample; the grid registers stay exact for the walk.
    sample_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (valid_d),
        .value   (lfsr_val)
    );

    assign mask_d = (accept ? in_step : step_q) - coord_t'(1);
    assign jit_x  = coord_t'(lfsr_val) & mask_d;
    assign jit_y  = coord_t'({lfsr_val[7:0], lfsr_val[15:8]}) & mask_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sx_q <= '0;
            sy_q <= '0;
        end else begin
            sx_q <= x_d + jit_x;
            sy_q <= y_d + jit_y;
        end
    end

    assign bus.sample_R14S = {sy_q, sx_q};
`else
    assign bus.sample_R14S = {y_q, x_q};
`endif

    assign bus.halt_RnnnnH    = halt_q;
    assign bus.validSamp_R14H = valid_q;
    assign bus.tri_R14S       = tri_q;
    assign bus.color_R14U     = color_q;
    assign state_dbg          = state_q;

endmodule

// File: tb/tb_sample_iterator.sv
// Directed bench for sample_iterator: a box-walk model fills the expected queue, one compare process checks every cycle.
module tb_sample_iterator;
  import raster_pkg::*;

  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  typedef logic signed [SIGFIG-1:0] coord_t;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  iter_state_t state_dbg;

  always #5 clk = ~clk;

  sample_iterator_if #(.SIGFIG(SIGFIG)) bus ();

  sample_iterator #(.SIGFIG(SIGFIG), .RADIX(RADIX)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [2*SIGFIG-1:0] exp_q[$];
  logic [3*3*SIGFIG-1:0] cur_tri = '0;
  logic [3*SIGFIG-1:0]   cur_color = '0;
  int cur_step = 1024;
  int cyc = 0;
  int last_valid_cyc = -100;
  int last_gap = -1;
  int seen = 0;

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Grid pitch straight from the subsample table at RADIX=10.
  function automatic int step_of(logic [3:0] ss);
    case (ss)
      4'b0100: return 512;
      4'b0010: return 256;
      4'b0001: return 128;
      default: return 1024;
    endcase
  endfunction

  // Model: every grid point of the box, rows bottom-up, x fastest.
  task automatic model_box(int llx, int lly, int urx, int ury, int step);
    int nx = (urx - llx) / step + 1;
    int ny = (ury - lly) / step + 1;
    for (int j = 0; j < ny; j++)
      for (int i = 0; i < nx; i++)
        exp_q.push_back({coord_t'(lly + j * step), coord_t'(llx + i * step)});
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [2*SIGFIG-1:0] e;
    cyc++;
    if (rst) begin
      chk("halt_is_not_valid", bus.halt_RnnnnH, !bus.validSamp_R14H);
      if (bus.validSamp_R14H) begin
        if (last_valid_cyc != cyc - 1) last_gap = cyc - last_valid_cyc - 1;
        last_valid_cyc = cyc;
        seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got %0h expected no sample", bus.sample_R14S);
        end else begin
          e = exp_q.pop_front();
`ifdef SAMPLE_JITTER_EN
          begin
            int jx = int'(coord_t'(bus.sample_R14S[0])) - int'(coord_t'(e[SIGFIG-1:0]));
            int jy = int'(coord_t'(bus.sample_R14S[1])) - int'(coord_t'(e[2*SIGFIG-1:SIGFIG]));
            chk("jitter_x_range", (jx >= 0 && jx < cur_step), 1'b1);
            chk("jitter_y_range", (jy >= 0 && jy < cur_step), 1'b1);
          end
`else
          chk("sample", bus.sample_R14S, e);
`endif
          chk("tri_latched", bus.tri_R14S, cur_tri);
          chk("color_latched", bus.color_R14U, cur_color);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge where the first sample must be visible.
  task automatic present(int llx, int lly, int urx, int ury, logic [3:0] ss);
    int guard = 0;
    bus.box_R13S[0][0] = coord_t'(llx);
    bus.box_R13S[0][1] = coord_t'(lly);
    bus.box_R13S[1][0] = coord_t'(urx);
    bus.box_R13S[1][1] = coord_t'(ury);
    bus.subSample_RnnnnU = ss;
    for (int v = 0; v < 3; v++)
      for (int a = 0; a < 3; a++)
        bus.tri_R13S[v][a] = 24'($urandom);
    for (int c = 0; c < 3; c++) bus.color_R13U[c] = 24'($urandom);
    bus.validTri_R13H = 1'b1;
    while (bus.halt_RnnnnH !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got halt=%0b expected halt=1 within 200 cycles", bus.halt_RnnnnH);
      bus.validTri_R13H = 1'b0;
      return;
    end
    @(posedge clk);
    cur_tri   = bus.tri_R13S;
    cur_color = bus.color_R13U;
    cur_step  = step_of(ss);
    model_box(llx, lly, urx, ury, cur_step);
    @(negedge clk);
    chk("first_sample_latency", bus.validSamp_R14H, 1'b1);
  endtask

  task automatic wait_done();
    int guard = 0;
    bus.validTri_R13H = 1'b0;
    while ((exp_q.size() != 0 || bus.halt_RnnnnH !== 1'b1) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("box_drained", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    bus.tri_R13S = '0;
    bus.color_R13U = '0;
    bus.box_R13S = '0;
    bus.validTri_R13H = 1'b0;
    bus.subSample_RnnnnU = SS_1X;

    // Pin the model against hand-computed grids while the DUT is held in reset.
    model_box(0, 0, 2048, 1024, 1024);
    chk("model_count_1x", exp_q.size(), 6);
    chk("model_s1", exp_q[1], {24'd0, 24'd1024});
    chk("model_s3", exp_q[3], {24'd1024, 24'd0});
    chk("model_s5", exp_q[5], {24'd1024, 24'd2048});
    exp_q.delete();
    model_box(-1024, -1024, 0, 0, 1024);
    chk("model_count_neg", exp_q.size(), 4);
    chk("model_neg_s0", exp_q[0], {24'hFFFC00, 24'hFFFC00});
    chk("model_neg_s1", exp_q[1], {24'hFFFC00, 24'd0});
    exp_q.delete();

    repeat (3) @(negedge clk);
    chk("reset_halt", bus.halt_RnnnnH, 1'b1);
    chk("reset_valid", bus.validSamp_R14H, 1'b0);
    chk("reset_sample", bus.sample_R14S, '0);
    chk("reset_tri", bus.tri_R14S, '0);
    chk("reset_color", bus.color_R14U, '0);
    chk("reset_state", state_dbg, WAIT);
    rst = 1'b1;
    @(negedge clk);

    // 1x, 3x2 grid
    s0 = seen;
    present(0, 0, 2048, 1024, 4'b1000);
    chk("t1_first_sample", bus.sample_R14S, {24'd0, 24'd0});
    wait_done();
    chk("t1_count", seen - s0, 6);
    chk("t1_halt_after", bus.halt_RnnnnH, 1'b1);

    // 4x degenerate box: a single sample, halt low for one cycle
    s0 = seen;
    present(512, 512, 512, 512, 4'b0100);
    chk("t2_sample", bus.sample_R14S, {24'd512, 24'd512});
    bus.validTri_R13H = 1'b0;
    @(negedge clk);
    chk("t2_halt_back", bus.halt_RnnnnH, 1'b1);
    chk("t2_valid_off", bus.validSamp_R14H, 1'b0);
    wait_done();
    chk("t2_count", seen - s0, 1);

    // Second triangle held during the box, subsample changed mid-box
    s0 = seen;
    present(0, 0, 1024, 1024, 4'b1000);
    present(0, 0, 512, 512, 4'b0100);
    @(negedge clk);
    chk("t3_idle_gap", last_gap, 1);
    wait_done();
    chk("t3_count", seen - s0, 8);

    // Reset on the third sample of a 16x box
    s0 = seen;
    present(0, 0, 512, 512, 4'b0010);
    bus.validTri_R13H = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t4_third_valid", bus.validSamp_R14H, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("t4_rst_valid", bus.validSamp_R14H, 1'b0);
    chk("t4_rst_halt", bus.halt_RnnnnH, 1'b1);
    chk("t4_rst_state", state_dbg, WAIT);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("t4_no_more_samples", seen - s0, 3);

    // Negative box, signed walk
    s0 = seen;
    present(-1024, -1024, 0, 0, 4'b1000);
    chk("t5_first_sample", bus.sample_R14S, {24'hFFFC00, 24'hFFFC00});
    wait_done();
    chk("t5_count", seen - s0, 4);

    // 64x box: 3x2 grid at step 128
    s0 = seen;
    present(0, 0, 256, 128, 4'b0001);
    wait_done();
    chk("t6_count", seen - s0, 6);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
